nibble_down_timer: RTL and testbench



---
 rtl/nibble_down_timer.sv | 101 ++++++++++
 tb/tb_nibble_down_timer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/nibble_down_timer.sv
// Programmable interval timer: NSLICE cascaded 4-bit down-counter slices with a nibble borrow chain.
// Optional feature macro: CNT_AUTORELOAD_EN (periodic reload from DONE instead of returning to IDLE).
module nibble_down_timer #(
    parameter  int NSLICE = 2,
    localparam int W      = 4 * NSLICE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [W-1:0]      load_val_i,
    input  logic              cnt_en_i,
    input  logic              abort_i,
    output logic              ready_o,
    output logic [W-1:0]      cnt_o,
    output logic [NSLICE-1:0] borrow_o,
    output logic              done_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [W-1:0]       r_cnt;
    logic [W-1:0]       r_reload;

    logic [NSLICE-1:0]  w_zero;
    logic [NSLICE-1:0]  w_chain;
    logic [W-1:0]       w_cnt_dec;
    logic               w_cnt_one;

    // w_chain[k]: slices 0..k are all zero, so slice k+1 must borrow.
    always_comb begin
        w_zero    = '0;
        w_chain   = '0;
        w_cnt_dec = r_cnt;
        for (int unsigned k = 0; k < NSLICE; k++) begin
            w_zero[k] = (r_cnt[4*k +: 4] == 4'h0);
            if (k == 0) begin
                w_chain[k]       = w_zero[k];
                w_cnt_dec[3:0]   = r_cnt[3:0] - 4'h1;
            end else begin
                w_chain[k] = w_chain[k-1] & w_zero[k];
                if (w_chain[k-1]) begin
                    w_cnt_dec[4*k +: 4] = r_cnt[4*k +: 4] - 4'h1;
                end
            end
        end
    end

    assign w_cnt_one = (r_cnt == W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_reload <= '0;
        end else if (abort_i && (r_state != S_IDLE)) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_reload <= load_val_i;
                        r_state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_cnt   <= r_reload;
                    r_state <= (r_reload != '0) ? S_RUN : S_DONE;
                end
                S_RUN: begin
                    if (cnt_en_i) begin
                        r_cnt <= w_cnt_dec;
                        if (w_cnt_one) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
`ifdef CNT_AUTORELOAD_EN
                    r_state <= S_LOAD;
`else
                    r_state <= S_IDLE;
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ready_o  = (r_state == S_IDLE);
    assign done_o   = (r_state == S_DONE);
    assign cnt_o    = r_cnt;
    assign borrow_o = {NSLICE{(r_state == S_RUN) && cnt_en_i}} & w_chain;

endmodule

// File: tb/tb_nibble_down_timer.sv
// Directed self-checking bench for nibble_down_timer (NSLICE=2); cycle N = N edges after start is accepted.
module tb_nibble_down_timer;

    localparam int NSLICE = 2;
    localparam int W      = 4 * NSLICE;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start_i;
    logic [W-1:0]      load_val_i;
    logic              cnt_en_i;
    logic              abort_i;
    logic              ready_o;
    logic [W-1:0]      cnt_o;
    logic [NSLICE-1:0] borrow_o;
    logic              done_o;

    int n_vec = 0;
    int n_err = 0;

    nibble_down_timer #(.NSLICE(NSLICE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .load_val_i (load_val_i),
        .cnt_en_i   (cnt_en_i),
        .abort_i    (abort_i),
        .ready_o    (ready_o),
        .cnt_o      (cnt_o),
        .borrow_o   (borrow_o),
        .done_o     (done_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept a start at the coming edge; returns in cycle 1 (LOAD).
    task automatic launch(input logic [W-1:0] v);
        start_i    = 1'b1;
        load_val_i = v;
        tick();
        start_i    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_i = 1'b0; load_val_i = '0; cnt_en_i = 1'b1; abort_i = 1'b0;
        #12;
        n_vec++; if (cnt_o !== 8'h00) begin n_err++; $display("FAIL reset_cnt got %h want 00", cnt_o); end
        n_vec++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", ready_o); end
        n_vec++; if (done_o !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done_o); end
        n_vec++; if (borrow_o !== 2'b00) begin n_err++; $display("FAIL reset_borrow got %b want 00", borrow_o); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_count3();
        logic [7:0] exp_cnt [4] = '{8'h03, 8'h02, 8'h01, 8'h00};
        launch(8'h03);
        n_vec++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL c3_load_ready got %b want 0", ready_o); end
        for (int c = 2; c <= 5; c++) begin
            tick();
            n_vec++; if (cnt_o !== exp_cnt[c-2]) begin n_err++; $display("FAIL c3_cnt cyc %0d got %h want %h", c, cnt_o, exp_cnt[c-2]); end
            n_vec++; if (done_o !== (c == 5)) begin n_err++; $display("FAIL c3_done cyc %0d got %b want %b", c, done_o, (c == 5)); end
        end
        tick();
        n_vec++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL c3_ready6 got %b want 1", ready_o); end
        n_vec++; if (done_o !== 1'b0) begin n_err++; $display("FAIL c3_done6 got %b want 0", done_o); end
    endtask

    task automatic test_borrow();
        logic [7:0] ec;
        logic [1:0] eb;
        launch(8'h10);
        tick();
        n_vec++; if (cnt_o !== 8'h10) begin n_err++; $display("FAIL br_cnt2 got %h want 10", cnt_o); end
        n_vec++; if (borrow_o !== 2'b01) begin n_err++; $display("FAIL br_borrow2 got %b want 01", borrow_o); end
        cnt_en_i = 1'b0; #1;
        n_vec++; if (borrow_o !== 2'b00) begin n_err++; $display("FAIL br_borrow_noen got %b want 00", borrow_o); end
        cnt_en_i = 1'b1; #1;
        for (int c = 3; c <= 18; c++) begin
            tick();
            ec = 8'(18 - c);
            eb = 2'b00;
            n_vec++; if (cnt_o !== ec) begin n_err++; $display("FAIL br_cnt cyc %0d got %h want %h", c, cnt_o, ec); end
            n_vec++; if (borrow_o !== eb) begin n_err++; $display("FAIL br_borrow cyc %0d got %b want %b", c, borrow_o, eb); end
            n_vec++; if (done_o !== (c == 18)) begin n_err++; $display("FAIL br_done cyc %0d got %b want %b", c, done_o, (c == 18)); end
        end
        tick();
    endtask

    task automatic test_enable_gap();
        launch(8'h02);
        tick();
        n_vec++; if (cnt_o !== 8'h02) begin n_err++; $display("FAIL gap_cnt2 got %h want 02", cnt_o); end
        tick();
        cnt_en_i = 1'b0;
        n_vec++; if (cnt_o !== 8'h01) begin n_err++; $display("FAIL gap_cnt3 got %h want 01", cnt_o); end
        tick();
        n_vec++; if (cnt_o !== 8'h01) begin n_err++; $display("FAIL gap_cnt4 got %h want 01", cnt_o); end
        tick();
        cnt_en_i = 1'b1;
        n_vec++; if (cnt_o !== 8'h01 || done_o !== 1'b0) begin n_err++; $display("FAIL gap_cyc5 got cnt %h done %b want 01/0", cnt_o, done_o); end
        tick();
        n_vec++; if (cnt_o !== 8'h00 || done_o !== 1'b1) begin n_err++; $display("FAIL gap_cyc6 got cnt %h done %b want 00/1", cnt_o, done_o); end
        tick();
    endtask

    task automatic test_zero();
        launch(8'h00);
        n_vec++; if (done_o !== 1'b0 || ready_o !== 1'b0) begin n_err++; $display("FAIL z_cyc1 got done %b ready %b want 0/0", done_o, ready_o); end
        tick();
        n_vec++; if (done_o !== 1'b1 || cnt_o !== 8'h00) begin n_err++; $display("FAIL z_cyc2 got done %b cnt %h want 1/00", done_o, cnt_o); end
        tick();
        n_vec++; if (ready_o !== 1'b1 || done_o !== 1'b0) begin n_err++; $display("FAIL z_cyc3 got ready %b done %b want 1/0", ready_o, done_o); end
    endtask

    task automatic test_abort();
        int dones = 0;
        launch(8'h05);
        tick(); tick(); tick();
        n_vec++; if (cnt_o !== 8'h03) begin n_err++; $display("FAIL ab_cnt4 got %h want 03", cnt_o); end
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        n_vec++; if (cnt_o !== 8'h00 || ready_o !== 1'b1 || done_o !== 1'b0) begin
            n_err++; $display("FAIL ab_cyc5 got cnt %h ready %b done %b want 00/1/0", cnt_o, ready_o, done_o);
        end
        for (int c = 0; c < 6; c++) begin
            tick();
            if (done_o) dones++;
        end
        n_vec++; if (dones !== 0) begin n_err++; $display("FAIL ab_nodone got %0d pulses want 0", dones); end
        // Abort in IDLE is ignored when start arrives with it
        abort_i = 1'b1;
        launch(8'h04);
        abort_i = 1'b0;
        n_vec++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL ab_idle_start got ready %b want 0", ready_o); end
        tick();
        n_vec++; if (cnt_o !== 8'h04) begin n_err++; $display("FAIL ab_idle_cnt got %h want 04", cnt_o); end
        abort_i = 1'b1; tick(); abort_i = 1'b0;
    endtask

    task automatic test_start_ignored();
        launch(8'h04);
        tick();
        start_i = 1'b1; load_val_i = 8'h09;
        tick();
        start_i = 1'b0;
        n_vec++; if (cnt_o !== 8'h03) begin n_err++; $display("FAIL si_cnt3 got %h want 03", cnt_o); end
        tick(); tick(); tick();
        n_vec++; if (done_o !== 1'b1 || cnt_o !== 8'h00) begin n_err++; $display("FAIL si_done6 got done %b cnt %h want 1/00", done_o, cnt_o); end
        tick();
    endtask

    task automatic test_async_reset();
        launch(8'h20);
        tick(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (cnt_o !== 8'h00 || ready_o !== 1'b1 || done_o !== 1'b0 || borrow_o !== 2'b00) begin
            n_err++; $display("FAIL ar_outputs got cnt %h ready %b done %b borrow %b want 00/1/0/00", cnt_o, ready_o, done_o, borrow_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

`ifdef CNT_AUTORELOAD_EN
    task automatic test_autoreload();
        launch(8'h02);
        for (int c = 2; c <= 13; c++) begin
            tick();
            n_vec++; if (done_o !== (c % 4 == 0)) begin n_err++; $display("FAIL arl_done cyc %0d got %b want %b", c, done_o, (c % 4 == 0)); end
            n_vec++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL arl_ready cyc %0d got %b want 0", c, ready_o); end
        end
        abort_i = 1'b1; tick(); abort_i = 1'b0;
        n_vec++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL arl_abort got ready %b want 1", ready_o); end
        tick(); tick(); tick(); tick();
        n_vec++; if (done_o !== 1'b0) begin n_err++; $display("FAIL arl_stopped got done %b want 0", done_o); end
    endtask
`endif

    initial begin
        test_reset();
        test_count3();
        test_borrow();
        test_enable_gap();
        test_zero();
        test_abort();
        test_start_ignored();
        test_async_reset();
`ifdef CNT_AUTORELOAD_EN
        test_autoreload();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
